// File: rtl/int_reservation_station.sv
// Integer reservation station: holds dispatched micro-ops and wakes their operands from the CDB.
// It issues the lowest-index fully-ready entry to the ALU over a valid/ready handshake.
module int_reservation_station #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned OP_W    = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [37:0]                    cdb_int,
    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [OP_W-1:0]                dispatch_op,
    input  logic [5:0]                     dispatch_dest,
    input  logic [32:0]                    src_data1,
    input  logic [32:0]                    src_data2,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [OP_W-1:0]                issue_op,
    output logic [5:0]                     issue_dest,
    output logic [31:0]                    issue_src1,
    output logic [31:0]                    issue_src2,
    output logic [$clog2(ENTRIES+1)-1:0]   entry_count
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] valid;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [5:0]         dest_q [ENTRIES];
    logic [32:0]        s1_q   [ENTRIES];
    logic [32:0]        s2_q   [ENTRIES];
    logic               lock;
    logic [IDX_W-1:0]   lock_idx;

    logic [ENTRIES-1:0] elig;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_fire;
    logic               dispatch_fire;

    // A pending operand captures CDB data when its tag matches a live broadcast.
    function automatic logic [32:0] wake_operand(input logic [32:0] s, input logic [37:0] cdb);
        if (!s[32] && (cdb[37:32] != 6'd0) && (s[5:0] == cdb[37:32]))
            return {1'b1, cdb[31:0]};
        return s;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(ENTRIES); i++)
            elig[i] = valid[i] & s1_q[i][32] & s2_q[i][32];
    end

    // Lowest-index eligible / free search; a stalled selection stays locked.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (elig[i])
                sel_idx = IDX_W'(i);
            if (!valid[i])
                free_idx = IDX_W'(i);
        end
        if (lock)
            sel_idx = lock_idx;
    end

    assign dispatch_ready = |(~valid);
    assign issue_valid    = ~flush & (lock | (|elig));
    assign issue_fire     = issue_valid & issue_ready;
    assign dispatch_fire  = dispatch_valid & dispatch_ready & ~flush;

    assign issue_op   = issue_valid ? op_q[sel_idx]         : '0;
    assign issue_dest = issue_valid ? dest_q[sel_idx]       : '0;
    assign issue_src1 = issue_valid ? s1_q[sel_idx][31:0]   : '0;
    assign issue_src2 = issue_valid ? s2_q[sel_idx][31:0]   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            lock        <= 1'b0;
            lock_idx    <= '0;
            entry_count <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                s1_q[i]   <= '0;
                s2_q[i]   <= '0;
            end
        end else if (flush) begin
            valid       <= '0;
            lock        <= 1'b0;
            entry_count <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                s1_q[i] <= wake_operand(s1_q[i], cdb_int);
                s2_q[i] <= wake_operand(s2_q[i], cdb_int);
            end
            if (issue_fire) begin
                valid[sel_idx] <= 1'b0;
                lock           <= 1'b0;
            end else if (issue_valid) begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end
            // The free slot is never the selected one, so this cannot collide with issue.
            if (dispatch_fire) begin
                valid[free_idx]  <= 1'b1;
                op_q[free_idx]   <= dispatch_op;
                dest_q[free_idx] <= dispatch_dest;
                s1_q[free_idx]   <= wake_operand(src_data1, cdb_int);
                s2_q[free_idx]   <= wake_operand(src_data2, cdb_int);
            end
            entry_count <= entry_count + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        end
    end
endmodule

// File: tb/tb_int_reservation_station.sv
// Bench for int_reservation_station: directed test-plan sequences, then random traffic checked
// every cycle against a slot-level behavioural model.
module tb_int_reservation_station;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [37:0] cdb_int;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [5:0]  dispatch_op;
    logic [5:0]  dispatch_dest;
    logic [32:0] src_data1;
    logic [32:0] src_data2;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_op;
    logic [5:0]  issue_dest;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [2:0]  entry_count;

    int total = 0;
    int bad   = 0;

    int_reservation_station #(.ENTRIES(4), .OP_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .cdb_int(cdb_int),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_dest(dispatch_dest),
        .src_data1(src_data1), .src_data2(src_data2),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: four slots, each a micro-op record, plus the stalled-selection latch.
    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [5:0]  dest;
        logic [32:0] s1;
        logic [32:0] s2;
    } ent_t;

    ent_t m[4];
    logic m_locked;
    int   m_lock_slot;

    function automatic logic [32:0] woken(input logic [32:0] s, input logic [37:0] cdb);
        if (!s[32] && cdb[37:32] != 6'd0 && s[5:0] == cdb[37:32])
            return {1'b1, cdb[31:0]};
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = '{1'b0, 6'd0, 6'd0, 33'd0, 33'd0};
        m_locked = 1'b0;
        m_lock_slot = 0;
    endtask

    function automatic int first_free();
        for (int i = 0; i < 4; i++) if (!m[i].v) return i;
        return -1;
    endfunction

    function automatic int chosen();
        if (m_locked) return m_lock_slot;
        for (int i = 0; i < 4; i++) if (m[i].v && m[i].s1[32] && m[i].s2[32]) return i;
        return -1;
    endfunction

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m[i].v) n++;
        return n;
    endfunction

    // Compare every output against the model for the inputs currently applied.
    task automatic compare_all();
        int  sel = chosen();
        logic iv = !flush && sel >= 0;
        check("dispatch_ready", 38'(dispatch_ready), 38'(first_free() >= 0));
        check("entry_count", 38'(entry_count), 38'(occupied()));
        check("issue_valid", 38'(issue_valid), 38'(iv));
        check("issue_op",   38'(issue_op),   iv ? 38'(m[sel].op)         : 38'd0);
        check("issue_dest", 38'(issue_dest), iv ? 38'(m[sel].dest)       : 38'd0);
        check("issue_src1", 38'(issue_src1), iv ? 38'(m[sel].s1[31:0])   : 38'd0);
        check("issue_src2", 38'(issue_src2), iv ? 38'(m[sel].s2[31:0])   : 38'd0);
    endtask

    // Advance the model across one clock edge using the applied inputs.
    task automatic model_step();
        int   sel  = chosen();
        int   fr   = first_free();
        logic iv   = !flush && sel >= 0;
        if (flush) begin
            for (int i = 0; i < 4; i++) m[i].v = 1'b0;
            m_locked = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (m[i].v) begin
                m[i].s1 = woken(m[i].s1, cdb_int);
                m[i].s2 = woken(m[i].s2, cdb_int);
            end
        end
        if (iv && issue_ready) begin
            m[sel].v = 1'b0;
            m_locked = 1'b0;
        end else if (iv) begin
            m_locked = 1'b1;
            m_lock_slot = sel;
        end
        if (dispatch_valid && fr >= 0)
            m[fr] = '{1'b1, dispatch_op, dispatch_dest,
                      woken(src_data1, cdb_int), woken(src_data2, cdb_int)};
    endtask

    task automatic cycle(input logic dv, input logic [5:0] op, input logic [5:0] dst,
                         input logic [32:0] a, input logic [32:0] b,
                         input logic [37:0] cdb, input logic ir, input logic fl);
        @(negedge clk);
        dispatch_valid = dv; dispatch_op = op; dispatch_dest = dst;
        src_data1 = a; src_data2 = b; cdb_int = cdb; issue_ready = ir; flush = fl;
        #1;
        compare_all();
        model_step();
    endtask

    task automatic idle(input logic ir, input logic [37:0] cdb);
        cycle(1'b0, 6'd0, 6'd0, 33'd0, 33'd0, cdb, ir, 1'b0);
    endtask

    function automatic logic [32:0] rdy(input logic [31:0] d);
        return {1'b1, d};
    endfunction

    function automatic logic [32:0] pend(input logic [5:0] t);
        return {1'b0, 26'd0, t};
    endfunction

    function automatic logic [32:0] rand_src();
        if ($urandom_range(1, 0) == 1) return {1'b1, 32'($urandom())};
        return {1'b0, 26'($urandom()), 6'($urandom_range(7, 1))};
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_int = '0; dispatch_valid = 1'b0;
        dispatch_op = '0; dispatch_dest = '0; src_data1 = '0; src_data2 = '0; issue_ready = 1'b0;
        model_reset();
        #12;
        check("rst_dispatch_ready", 38'(dispatch_ready), 38'd1);
        check("rst_issue_valid", 38'(issue_valid), 38'd0);
        check("rst_entry_count", 38'(entry_count), 38'd0);
        check("rst_issue_dest", 38'(issue_dest), 38'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ready dispatch issues the next cycle and leaves the station empty.
        cycle(1'b1, 6'd5, 6'd3, rdy(32'd10), rdy(32'd20), 38'd0, 1'b1, 1'b0);
        idle(1'b1, 38'd0);
        check("tp1_valid", 38'(issue_valid), 38'd1);
        check("tp1_src1", 38'(issue_src1), 38'd10);
        check("tp1_src2", 38'(issue_src2), 38'd20);
        check("tp1_dest", 38'(issue_dest), 38'd3);
        idle(1'b1, 38'd0);
        check("tp1_count", 38'(entry_count), 38'd0);

        // Wakeup: eligible only the cycle after the broadcast.
        cycle(1'b1, 6'd1, 6'd4, pend(6'd7), rdy(32'd5), 38'd0, 1'b1, 1'b0);
        idle(1'b1, {6'd7, 32'hDEAD});
        check("tp2_no_issue_cdb_cycle", 38'(issue_valid), 38'd0);
        idle(1'b1, 38'd0);
        check("tp2_valid", 38'(issue_valid), 38'd1);
        check("tp2_src1", 38'(issue_src1), 38'hDEAD);

        // Same-cycle CDB capture on dispatch.
        cycle(1'b1, 6'd2, 6'd5, rdy(32'd1), pend(6'd9), {6'd9, 32'd42}, 1'b1, 1'b0);
        idle(1'b1, 38'd0);
        check("tp3_valid", 38'(issue_valid), 38'd1);
        check("tp3_src2", 38'(issue_src2), 38'd42);
        idle(1'b1, 38'd0);

        // Fill and stall, then drain in index order.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 6'(i), 6'(10 + i), rdy(32'(i)), rdy(32'(i + 100)), 38'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 38'd0);
            check("tp4_full", 38'(dispatch_ready), 38'd0);
            check("tp4_count", 38'(entry_count), 38'd4);
            check("tp4_stall_dest", 38'(issue_dest), 38'd10);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 38'd0);
            check("tp4_drain_dest", 38'(issue_dest), 38'(10 + i));
        end

        // Lock holds entry 1 even after entry 0 wakes.
        cycle(1'b1, 6'd0, 6'd20, pend(6'd3), rdy(32'd0), 38'd0, 1'b0, 1'b0);
        cycle(1'b1, 6'd0, 6'd21, rdy(32'd1), rdy(32'd2), 38'd0, 1'b0, 1'b0);
        idle(1'b0, 38'd0);
        check("tp5_presented", 38'(issue_dest), 38'd21);
        idle(1'b0, {6'd3, 32'd77});
        idle(1'b0, 38'd0);
        check("tp5_locked", 38'(issue_dest), 38'd21);
        idle(1'b1, 38'd0);
        check("tp5_handshake", 38'(issue_dest), 38'd21);
        idle(1'b1, 38'd0);
        check("tp5_then_e0", 38'(issue_dest), 38'd20);

        // Flush with concurrent dispatch.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 6'd0, 6'(30 + i), pend(6'(50 + i)), rdy(32'd0), 38'd0, 1'b1, 1'b0);
        cycle(1'b1, 6'd1, 6'd40, rdy(32'd1), rdy(32'd1), 38'd0, 1'b1, 1'b1);
        idle(1'b1, 38'd0);
        check("tp6_count", 38'(entry_count), 38'd0);
        check("tp6_ready", 38'(dispatch_ready), 38'd1);
        check("tp6_no_issue", 38'(issue_valid), 38'd0);

        // Async reset in the middle of a stall.
        cycle(1'b1, 6'd1, 6'd41, rdy(32'd1), rdy(32'd1), 38'd0, 1'b0, 1'b0);
        idle(1'b0, 38'd0);
        check("tp6_stalled", 38'(issue_valid), 38'd1);
        #2 reset = 1'b1;
        #1;
        check("tp6_async_reset", 38'(issue_valid), 38'd0);
        check("tp6_async_count", 38'(entry_count), 38'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [37:0] cdb;
            cdb = {6'($urandom_range(7, 0)), 32'($urandom())};
            cycle($urandom_range(9, 0) < 7, 6'($urandom()), 6'($urandom_range(63, 1)),
                  rand_src(), rand_src(), cdb, $urandom_range(9, 0) < 6,
                  $urandom_range(63, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
